// File: rtl/ram_burst_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ram_burst_ctrl
// Description : Burst command front-end for a single-port synchronous RAM.
//               Optional CLEAR command enabled by RAM_BURST_CTRL_CLEAR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_burst_ctrl #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_rst,
    input  logic [DATA_W-1:0] ram_dout
);

`ifdef RAM_BURST_CTRL_CLEAR_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        CLR  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_t;
`endif

    localparam logic [LEN_W:0]    c_len_one  = 1;
    localparam logic [ADDR_W-1:0] c_addr_one = 1;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_cur;
    logic [LEN_W:0]      r_left;
    logic                r_stage_a;   // read address presented to RAM this cycle
    logic                r_stage_b;   // RAM dout carries a read beat this cycle
    logic [DATA_W-1:0]   r_fifo [2];
    logic                r_wptr;
    logic                r_rptr;
    logic [1:0]          r_count;

    logic                w_pop;
    logic                w_push;
    logic [2:0]          w_occ;
    logic                w_issue;

    assign cmd_ready = (r_state == IDLE);
    assign wr_ready  = (r_state == WR);
    assign busy      = (r_state != IDLE);
    assign rd_valid  = (r_count != 2'd0);
    assign rd_data   = r_fifo[r_rptr];

    assign w_pop  = rd_valid && rd_ready;
    assign w_push = r_stage_b;

    // Occupancy after this cycle's pop; issuing keeps FIFO + in-flight <= 2.
    assign w_occ   = {1'b0, r_count} - {2'b00, w_pop}
                   + {2'b00, r_stage_a} + {2'b00, r_stage_b};
    assign w_issue = (r_state == RD) && (r_left != '0) && (w_occ < 3'd2);

`ifndef RAM_BURST_CTRL_CLEAR_EN
    assign ram_rst = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cur     <= '0;
            r_left    <= '0;
            r_stage_a <= 1'b0;
            r_stage_b <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
`ifdef RAM_BURST_CTRL_CLEAR_EN
            ram_rst   <= 1'b0;
`endif
        end else begin
            ram_we    <= 1'b0;
            r_stage_a <= w_issue;
            r_stage_b <= r_stage_a;
`ifdef RAM_BURST_CTRL_CLEAR_EN
            ram_rst   <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_cur  <= cmd_addr;
                        r_left <= {1'b0, cmd_len} + c_len_one;
`ifdef RAM_BURST_CTRL_CLEAR_EN
                        if (cmd_write && (&cmd_len) && (&cmd_addr)) begin
                            r_state <= CLR;
                            ram_rst <= 1'b1;
                        end else
`endif
                        if (cmd_write) begin
                            r_state <= WR;
                        end else begin
                            r_state <= RD;
                        end
                    end
                end
                WR: begin
                    if (wr_valid) begin
                        ram_we   <= 1'b1;
                        ram_addr <= r_cur;
                        ram_din  <= wr_data;
                        r_cur    <= r_cur + c_addr_one;
                        r_left   <= r_left - c_len_one;
                        if (r_left == c_len_one) begin
                            r_state <= IDLE;
                        end
                    end
                end
                RD: begin
                    if (w_issue) begin
                        ram_addr <= r_cur;
                        r_cur    <= r_cur + c_addr_one;
                        r_left   <= r_left - c_len_one;
                    end else if ((r_left == '0) && !r_stage_a && !r_stage_b
                                 && (r_count == 2'd0)) begin
                        r_state <= IDLE;
                    end
                end
`ifdef RAM_BURST_CTRL_CLEAR_EN
                CLR: begin
                    // First CLR cycle pulses ram_rst; the second lets dout settle to zero.
                    if (!ram_rst) begin
                        r_state <= IDLE;
                    end
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fifo[0] <= '0;
            r_fifo[1] <= '0;
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_count   <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= ram_dout;
                r_wptr         <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_burst_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ram_burst_ctrl
// Description : Directed scoreboard bench for ram_burst_ctrl with a RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_burst_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [5:0] cmd_addr, cmd_len;
    logic       wr_valid, wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid, rd_ready;
    logic [7:0] rd_data;
    logic       busy, ram_we, ram_rst;
    logic [5:0] ram_addr;
    logic [7:0] ram_din, ram_dout;

    always #5 clk = ~clk;

    ram_burst_ctrl #(.ADDR_W(6), .DATA_W(8), .LEN_W(6)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_rst(ram_rst), .ram_dout(ram_dout)
    );

    // 64x8 single-port synchronous RAM with synchronous clear
    logic [7:0] mem [0:63];
    always @(posedge clk) begin
        if (ram_rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
            ram_dout <= 8'h00;
        end else begin
            if (ram_we) mem[ram_addr] <= ram_din;
            ram_dout <= mem[ram_addr];
        end
    end

    int tests = 0;
    int fails = 0;
    logic [7:0]  model [0:63];
    logic [7:0]  exp_rd [$];
    logic [13:0] exp_we [$];

    logic [7:0]  rd_obs [0:511];
    logic [13:0] we_obs [0:511];
    int          we_cyc [0:511];
    int          rd_n = 0, we_n = 0, cyc = 0, stall_viol = 0, rst_pulses = 0;
    int          rd_i = 0, we_i = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (rd_valid && rd_ready) begin
                rd_obs[rd_n] <= rd_data;
                rd_n <= rd_n + 1;
            end
            if (ram_we) begin
                we_obs[we_n] <= {ram_addr, ram_din};
                we_cyc[we_n] <= cyc;
                we_n <= we_n + 1;
            end
            if (ram_rst) rst_pulses <= rst_pulses + 1;
            if (prev_stall && (!rd_valid || rd_data !== prev_data)) stall_viol <= stall_viol + 1;
            prev_stall <= rd_valid && !rd_ready;
            prev_data  <= rd_data;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic w, input logic [5:0] a, input logic [5:0] l);
        int n;
        n = 0;
        cmd_write = w; cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_accept", {31'b0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic push_read(input logic [5:0] a, input logic [5:0] l);
        logic [5:0] ad;
        for (int i = 0; i <= int'(l); i++) begin
            ad = a + 6'(i);
            exp_rd.push_back(model[ad]);
        end
    endtask

    task automatic wait_idle(input bit toggle, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 1000) begin
            tick();
            n++;
            if (toggle) rd_ready = (n % 3 == 0);
            @(negedge clk);
        end
        chk({tag, "_done"}, {31'b0, busy}, 32'd0);
        rd_ready = 1'b1;
        tick();
    endtask

    task automatic check_rd(input string tag);
        chk({tag, "_beats"}, rd_n - rd_i, exp_rd.size());
        while (exp_rd.size() > 0 && rd_i < rd_n) begin
            chk({tag, "_data"}, rd_obs[rd_i], exp_rd.pop_front());
            rd_i++;
        end
        exp_rd.delete();
        rd_i = rd_n;
    endtask

    task automatic check_we(input string tag);
        chk({tag, "_beats"}, we_n - we_i, exp_we.size());
        while (exp_we.size() > 0 && we_i < we_n) begin
            chk({tag, "_addr_din"}, we_obs[we_i], exp_we.pop_front());
            we_i++;
        end
        exp_we.delete();
        we_i = we_n;
    endtask

    task automatic wr_burst(input logic [5:0] a, input int n, input logic [7:0] base,
                            input logic [7:0] step, input int delay, input string tag);
        logic [5:0] ad;
        logic [7:0] d;
        bit held;
        int t;
        send_cmd(1'b1, a, 6'(n - 1));
        held = 1'b1;
        for (int k = 0; k < delay; k++) begin
            @(negedge clk);
            if (!busy || !wr_ready) held = 1'b0;
            tick();
        end
        if (delay > 0) chk({tag, "_busy_held"}, {31'b0, held}, 32'd1);
        for (int i = 0; i < n; i++) begin
            ad = a + 6'(i);
            d  = base + 8'(i) * step;
            wr_valid = 1'b1;
            wr_data  = d;
            model[ad] = d;
            exp_we.push_back({ad, d});
            t = 0;
            @(negedge clk);
            while (!wr_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            tick();
        end
        wr_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_idle_we_last"}, {30'b0, busy, ram_we}, 32'd1);
        tick();
    endtask

    task automatic rd_burst(input logic [5:0] a, input logic [5:0] l, input bit toggle,
                            input bit lat_chk, input string tag);
        int n;
        push_read(a, l);
        rd_ready = 1'b1;
        send_cmd(1'b0, a, l);
        if (lat_chk) begin
            n = 0;
            @(negedge clk);
            while (!rd_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk({tag, "_latency"}, n, 32'd3);
        end
        wait_idle(toggle, tag);
        check_rd(tag);
    endtask

    initial begin
        int we_start, sv0, viol, n;
`ifdef RAM_BURST_CTRL_CLEAR_EN
        int rp0;
`endif
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("rst_wr_ready",  {31'b0, wr_ready},  32'd0);
        chk("rst_rd_valid",  {31'b0, rd_valid},  32'd0);
        chk("rst_rd_data",   {24'b0, rd_data},   32'd0);
        chk("rst_busy",      {31'b0, busy},      32'd0);
        chk("rst_ram_we",    {31'b0, ram_we},    32'd0);
        chk("rst_ram_addr",  {26'b0, ram_addr},  32'd0);
        chk("rst_ram_din",   {24'b0, ram_din},   32'd0);
        chk("rst_ram_rst",   {31'b0, ram_rst},   32'd0);
        rst = 1'b0;
        tick();

        // Full-depth write starting mid-array: wraps and initialises every address
        wr_burst(6'h20, 64, 8'h07, 8'h03, 0, "fill");
        check_we("fill_we");

        // Reset while the third beat of a five-beat write is pending in ram_we
        send_cmd(1'b1, 6'h11, 6'd4);
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'hB1 + 8'(i);
            if (i < 2) begin
                model[6'h11 + 6'(i)] = 8'hB1 + 8'(i);
                exp_we.push_back({6'h11 + 6'(i), 8'hB1 + 8'(i)});
            end
            @(negedge clk);
            tick();
        end
        rst = 1'b1;
        wr_valid = 1'b0;
        #1;
        chk("mr_ram_we",    {31'b0, ram_we},    32'd0);
        chk("mr_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("mr_busy",      {31'b0, busy},      32'd0);
        chk("mr_wr_ready",  {31'b0, wr_ready},  32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        check_we("mr_we");
        rd_burst(6'h11, 6'd2, 1'b0, 1'b0, "mr_rd");

        // Wrapping write then read-back with first-beat latency
        we_start = we_n;
        wr_burst(6'h3E, 4, 8'hA0, 8'h01, 0, "wrap");
        chk("wrap_we_consec", we_cyc[we_start + 3] - we_cyc[we_start], 32'd3);
        check_we("wrap_we");
        rd_burst(6'h3E, 6'd3, 1'b0, 1'b1, "wrap_rd");

        // Read under rd_ready backpressure 1,0,0,1,...
        sv0 = stall_viol;
        rd_burst(6'h00, 6'd7, 1'b1, 1'b0, "stall_rd");
        chk("stall_stable", stall_viol - sv0, 32'd0);

        // Single-beat write with late wr_valid
        wr_burst(6'h05, 1, 8'h5A, 8'h00, 4, "late");
        check_we("late_we");

        // cmd_valid held high across an active read
        push_read(6'h10, 6'd5);
        cmd_write = 1'b0; cmd_addr = 6'h10; cmd_len = 6'd5; cmd_valid = 1'b1;
        @(negedge clk);
        tick();
        cmd_addr = 6'h30; cmd_len = 6'd1;
        push_read(6'h30, 6'd1);
        viol = 0;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            if (cmd_ready) viol++;
            tick();
            n++;
            @(negedge clk);
        end
        chk("hold_no_accept", viol, 32'd0);
        chk("hold_idle_ready", {31'b0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
        chk("hold_next_accept", {31'b0, busy}, 32'd1);
        wait_idle(1'b0, "hold");
        check_rd("hold_rd");

`ifdef RAM_BURST_CTRL_CLEAR_EN
        wr_burst(6'h00, 64, 8'hFF, 8'h00, 0, "fill_ff");
        check_we("fill_ff_we");
        rp0 = rst_pulses;
        send_cmd(1'b1, 6'h3F, 6'h3F);
        @(negedge clk);
        chk("clr_c0", {30'b0, busy, ram_rst}, 32'd3);
        tick();
        @(negedge clk);
        chk("clr_c1", {30'b0, busy, ram_rst}, 32'd2);
        tick();
        @(negedge clk);
        chk("clr_idle", {31'b0, busy}, 32'd0);
        tick();
        chk("clr_pulses", rst_pulses - rp0, 32'd1);
        chk("clr_no_we", we_n - we_i, 32'd0);
        for (int i = 0; i < 64; i++) model[i] = 8'h00;
        rd_burst(6'h00, 6'h3F, 1'b0, 1'b0, "clr_rd");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
